// File: rtl/wallace_mul_pipe_pkg.sv
// Shared row type and compile-time helpers for the pipelined Wallace multiplier:
// Wallace depth for n rows and the split of CSA levels across pipeline stages.
package wallace_pkg;

    localparam int MAX_WIDTH = 32;

    typedef logic [2*MAX_WIDTH-1:0] pp_row_t;

    // One Wallace level turns every full group of three rows into two.
    function automatic int rows_after(input int n);
        return 2 * (n / 3) + n % 3;
    endfunction

    function automatic int rows_at_level(input int w, input int lvl);
        int n;
        n = w;
        for (int l = 0; l < lvl; l++) begin
            if (n > 2) n = rows_after(n);
        end
        return n;
    endfunction

    function automatic int csa_levels(input int w);
        int n;
        int l;
        n = w;
        l = 0;
        while (n > 2) begin
            n = rows_after(n);
            l++;
        end
        return l;
    endfunction

    function automatic int first_half(input int w);
        return (csa_levels(w) + 1) / 2;
    endfunction

    // Stage 1 takes the first half of the levels; the rest spread evenly over stages 2..p.
    function automatic int stage_lvl_lo(input int w, input int p, input int s);
        int h;
        h = first_half(w);
        if (p == 1 || s == 1) return 0;
        return h + ((s - 2) * (csa_levels(w) - h)) / (p - 1);
    endfunction

    function automatic int stage_lvl_hi(input int w, input int p, input int s);
        int h;
        h = first_half(w);
        if (p == 1) return csa_levels(w);
        if (s == 1) return h;
        return h + ((s - 1) * (csa_levels(w) - h)) / (p - 1);
    endfunction

endpackage

// File: rtl/wallace_mul_pipe_if.sv
// Operand/product bus of the pipelined Wallace multiplier.
interface wallace_mul_pipe_if #(
    parameter int WIDTH = 8
);
    // Valid/ready: a beat moves when valid & ready are both high at a rising edge;
    // a source holds valid and its payload stable until that happens, and ready
    // never depends on valid of the same side.
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               is_signed;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/wallace_mul_pipe_csa_tree.sv
// Combinational carry-save compression of partial-product rows over Wallace
// levels [LEVEL_LO, LEVEL_HI); an empty range is a plain pass-through.
module wallace_csa_tree
    import wallace_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int LEVEL_LO = 0,
    parameter int LEVEL_HI = 1
) (
    input  logic [rows_at_level(WIDTH, LEVEL_LO)-1:0][2*WIDTH-1:0] rows_in,
    output logic [rows_at_level(WIDTH, LEVEL_HI)-1:0][2*WIDTH-1:0] rows_out
);
    localparam int RW  = 2 * WIDTH;
    localparam int NLV = LEVEL_HI - LEVEL_LO;

    for (genvar k = 0; k < NLV; k++) begin : g_lvl
        localparam int NI = rows_at_level(WIDTH, LEVEL_LO + k);
        localparam int NO = rows_at_level(WIDTH, LEVEL_LO + k + 1);
        localparam int NG = NI / 3;

        logic [NI-1:0][RW-1:0] src;
        logic [NO-1:0][RW-1:0] dst;

        if (k == 0) begin : g_first
            assign src = rows_in;
        end else begin : g_next
            assign src = g_lvl[k-1].dst;
        end

        // Each group is a row of 3:2 full adders; the carry row moves up one column.
        for (genvar g = 0; g < NG; g++) begin : g_csa
            assign dst[2*g]   = src[3*g] ^ src[3*g+1] ^ src[3*g+2];
            assign dst[2*g+1] = ((src[3*g] & src[3*g+1]) |
                                 (src[3*g] & src[3*g+2]) |
                                 (src[3*g+1] & src[3*g+2])) << 1;
        end

        for (genvar r = 0; r < NI - 3*NG; r++) begin : g_pass
            assign dst[2*NG + r] = src[3*NG + r];
        end
    end

    if (NLV == 0) begin : g_bypass
        assign rows_out = rows_in;
    end else begin : g_tail
        assign rows_out = g_lvl[NLV-1].dst;
    end

endmodule

// File: rtl/wallace_mul_pipe.sv
// Pipelined WIDTH x WIDTH Wallace-tree multiplier with a globally stalled pipe.
// Define WALLACE_MUL_SIGNED_EN to add Baugh-Wooley signed operands selected by is_signed.
module wallace_mul_pipe
    import wallace_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int PIPE_STAGES = 3
) (
    input logic             clk,
    input logic             rst_n,
    wallace_mul_pipe_if.slave bus
);
    localparam int RW = 2 * WIDTH;

    logic                   advance;
    logic                   out_valid;
    logic [WIDTH-1:0][RW-1:0] pp;

`ifdef WALLACE_MUL_SIGNED_EN
    logic sgn;
    assign sgn = bus.is_signed;
`else
    logic unused_sign;
    assign unused_sign = bus.is_signed;
`endif

    // Row i holds a & b[i] shifted to column i; constants fit into free columns of row 0.
    always_comb begin
        pp = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp[i][i+j] = bus.a[j] & bus.b[i];
`ifdef WALLACE_MUL_SIGNED_EN
                if (sgn && ((i == WIDTH-1) != (j == WIDTH-1)))
                    pp[i][i+j] = ~(bus.a[j] & bus.b[i]);
`endif
            end
        end
`ifdef WALLACE_MUL_SIGNED_EN
        if (sgn) begin
            pp[0][WIDTH] = 1'b1;
            pp[0][RW-1]  = 1'b1;
        end
`endif
    end

    for (genvar s = 1; s <= PIPE_STAGES; s++) begin : g_st
        localparam int LO = stage_lvl_lo(WIDTH, PIPE_STAGES, s);
        localparam int HI = stage_lvl_hi(WIDTH, PIPE_STAGES, s);
        localparam int NI = rows_at_level(WIDTH, LO);
        localparam int NO = rows_at_level(WIDTH, HI);

        logic                  prev_v;
        logic                  v_q;
        logic [NI-1:0][RW-1:0] d_in;
        logic [NO-1:0][RW-1:0] d_out;

        if (s == 1) begin : g_src_in
            assign prev_v = bus.in_valid;
            assign d_in   = pp;
        end else begin : g_src_reg
            assign prev_v = g_st[s-1].v_q;
            assign d_in   = g_st[s-1].g_reg.q;
        end

        wallace_csa_tree #(
            .WIDTH    (WIDTH),
            .LEVEL_LO (LO),
            .LEVEL_HI (HI)
        ) u_tree (
            .rows_in  (d_in),
            .rows_out (d_out)
        );

        always_ff @(posedge clk) begin
            if (!rst_n)       v_q <= 1'b0;
            else if (advance) v_q <= prev_v;
        end

        // Data only loads behind a valid beat, so bubbles leave the last result in place.
        if (s < PIPE_STAGES) begin : g_reg
            logic [NO-1:0][RW-1:0] q;
            always_ff @(posedge clk) begin
                if (!rst_n)                 q <= '0;
                else if (advance && prev_v) q <= d_out;
            end
        end else begin : g_out
            logic [RW-1:0] p_q;
            always_ff @(posedge clk) begin
                if (!rst_n)                 p_q <= '0;
                else if (advance && prev_v) p_q <= d_out[0] + d_out[1];
            end
        end
    end

    assign out_valid     = g_st[PIPE_STAGES].v_q;
    assign advance       = !out_valid || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid;
    assign bus.product   = g_st[PIPE_STAGES].g_out.p_q;

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Bench for wallace_mul_pipe: directed latency/stream/backpressure/reset cases and a
// randomized sweep, scored against a plain-arithmetic multiply model.
module tb_wallace_mul_pipe #(
    parameter int WIDTH       = 8,
    parameter int PIPE_STAGES = 3
);
    localparam int PW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MAXV = '1;
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wallace_mul_pipe_if #(.WIDTH(WIDTH)) bus ();

    wallace_mul_pipe #(
        .WIDTH       (WIDTH),
        .PIPE_STAGES (PIPE_STAGES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [PW-1:0] exp_q[$];
    int            in_cyc_q[$];
    int            out_cyc_q[$];
    int            n_checks = 0;
    int            n_errors = 0;

    function automatic logic [PW-1:0] ref_mul(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic s);
        longint px;
        longint py;
        px = longint'(x);
        py = longint'(y);
`ifdef WALLACE_MUL_SIGNED_EN
        if (s) begin
            px = longint'($signed(x));
            py = longint'($signed(y));
        end
`endif
        return PW'(px * py);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Input monitor: an accept seen at the negedge completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) begin
            exp_q.push_back(ref_mul(bus.a, bus.b, bus.is_signed));
            in_cyc_q.push_back(cyc);
        end
    end

    logic          hold_prev = 1'b0;
    logic [PW-1:0] hold_p = '0;

    // Output monitor: scores transfers and checks that a stalled output stays frozen.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("stall_out_valid", bus.out_valid, 1);
                check("stall_product", bus.product, hold_p);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("output_with_empty_queue", bus.out_valid, 0);
                else check("product", bus.product, exp_q.pop_front());
                out_cyc_q.push_back(cyc);
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            hold_p    = bus.product;
        end
    end

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        int budget;
        bus.in_valid  = 1'b1;
        bus.a         = x;
        bus.b         = y;
        bus.is_signed = s;
        budget = 0;
        @(negedge clk);
        while (!bus.in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.in_ready) check("send_accept_timeout", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return MAXV;
            2:       return MINV;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] held;
        logic          acc;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_product", bus.product, 0);
        check("reset_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Largest unsigned operands; latency from accept to out_valid.
        in_cyc_q.delete();
        out_cyc_q.delete();
        send(MAXV, MAXV, 1'b0);
        drain();
        check("latency_count", out_cyc_q.size(), 1);
        if (out_cyc_q.size() == 1 && in_cyc_q.size() == 1)
            check("latency", out_cyc_q[0] - in_cyc_q[0], PIPE_STAGES);

        // Back-to-back stream at full throughput.
        in_cyc_q.delete();
        out_cyc_q.delete();
        send(WIDTH'(3), WIDTH'(5), 1'b0);
        send(WIDTH'(0), WIDTH'(200), 1'b0);
        send(WIDTH'(128), WIDTH'(2), 1'b0);
        send(WIDTH'(17), WIDTH'(15), 1'b0);
        drain();
        check("stream_count", out_cyc_q.size(), 4);
        for (int i = 1; i < out_cyc_q.size(); i++)
            check("stream_back_to_back", out_cyc_q[i] - out_cyc_q[i-1], 1);
        for (int i = 0; i < out_cyc_q.size() && i < in_cyc_q.size(); i++)
            check("stream_latency", out_cyc_q[i] - in_cyc_q[i], PIPE_STAGES);

        // Backpressure: fill the pipe, hold the output for four cycles, then release.
        bus.out_ready = 1'b0;
        for (int i = 0; i < PIPE_STAGES; i++) send(pick_operand(), pick_operand(), 1'b0);
        bus.in_valid  = 1'b1;
        bus.a         = pick_operand();
        bus.b         = pick_operand();
        bus.is_signed = 1'b0;
        @(negedge clk);
        held = bus.product;
        check("bp_out_valid", bus.out_valid, 1);
        check("bp_in_ready_low", bus.in_ready, 0);
        repeat (4) begin
            @(negedge clk);
            check("bp_in_ready_low", bus.in_ready, 0);
            check("bp_product_stable", bus.product, held);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        drain();

        // Signed and unsigned operations mixed in flight.
        send(MINV, MINV, 1'b1);
        send(MAXV, WIDTH'(1), 1'b1);
        send(MAXV, WIDTH'(1), 1'b0);
        send(MINV, MAXV, 1'b1);
        send(WIDTH'(5), MAXV, 1'b0);
        send(WIDTH'(3), MINV, 1'b1);
        drain();

        // Reset with operations in flight: nothing may emerge afterwards.
        for (int i = 0; i < 3; i++) send(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        check("flush_product", bus.product, 0);
        repeat (PIPE_STAGES + 2) begin
            check("flush_out_valid", bus.out_valid, 0);
            check("flush_in_ready", bus.in_ready, 1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;

        // Randomized sweep with random input valid and output backpressure.
        acc = 1'b1;
        for (int c = 0; c < 800; c++) begin
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if (acc || !bus.in_valid) begin
                bus.in_valid  = ($urandom_range(0, 9) < 7);
                bus.a         = pick_operand();
                bus.b         = pick_operand();
                bus.is_signed = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
